// File: rtl/naneye_cfg_tx_pkg.sv
// naneye_cfg_tx_pkg: FSM encoding and default link timing shared by the config transmitter
package naneye_cfg_tx_pkg;
  typedef enum logic [2:0] {IDLE, LEAD, PRE, DATA, PARITY, GUARD, DONE} state_t;
  localparam int WORD_W_DEF = 16;
  localparam int PRE_BITS_DEF = 2;
  localparam int HALF_CYC_DEF = 30;
  localparam int LEAD_CYC_DEF = 16;
  localparam int GUARD_CYC_DEF = 16;
  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/naneye_cfg_tx_if.sv
// naneye_cfg_tx_if: host write port, RX_DECODER slot handshake and line pad signals
interface naneye_cfg_tx_if
  import naneye_cfg_tx_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
);
  logic cfg_wr;
  logic [WORD_W-1:0] cfg_data;
  logic cfg_busy;
  logic config_en;
  logic config_done;
  logic ser_out;
  logic ser_oe;
  logic [7:0] tx_count;
  modport master (output cfg_wr, cfg_data, config_en, input cfg_busy, config_done, ser_out, ser_oe, tx_count);
  modport slave (input cfg_wr, cfg_data, config_en, output cfg_busy, config_done, ser_out, ser_oe, tx_count);
endinterface

// File: rtl/naneye_cfg_tx_enc.sv
// naneye_cfg_tx_enc: Manchester bit encoder owning the half-bit counter
module naneye_cfg_tx_enc #(
  parameter int HALF_CYC = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_value,
  output logic level,
  output logic bit_done
);
  localparam int HW = HALF_CYC > 1 ? $clog2(HALF_CYC) : 1;
  localparam logic [HW-1:0] HC_LAST = HW'(HALF_CYC - 1);
  logic [HW-1:0] hc;
  logic active, half;
  assign bit_done = active && half && hc == HC_LAST;
  // start loads a bit (priority gives gapless reload), level flips mid-bit, line drops low when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      half <= 1'b0;
      hc <= '0;
      level <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      half <= 1'b0;
      hc <= '0;
      level <= bit_value;
    end else if (active) begin
      hc <= hc == HC_LAST ? '0 : hc + 1'b1;
      if (hc == HC_LAST) begin
        half <= 1'b1;
        active <= !half;
        level <= half ? 1'b0 : !level;
      end
    end
  end
endmodule

// File: rtl/naneye_cfg_tx.sv
// naneye_cfg_tx: holds one config word and Manchester-sends it when RX_DECODER opens a slot
module naneye_cfg_tx
  import naneye_cfg_tx_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int PRE_BITS = PRE_BITS_DEF,
  parameter int HALF_CYC = HALF_CYC_DEF,
  parameter int LEAD_CYC = LEAD_CYC_DEF,
  parameter int GUARD_CYC = GUARD_CYC_DEF
) (
  input logic clk,
  input logic rst,
  naneye_cfg_tx_if.slave bus
);
  localparam int BW = $clog2(PRE_BITS + WORD_W + 2);
  localparam int PW = $clog2(imax(LEAD_CYC, GUARD_CYC) + 1);
  localparam logic [BW-1:0] B_PRE = BW'(PRE_BITS);
  localparam logic [BW-1:0] B_DAT = BW'(PRE_BITS + WORD_W);
  localparam logic [BW-1:0] B_TOT = BW'(PRE_BITS + WORD_W + 1);
  localparam logic [PW-1:0] P_LEAD = PW'(LEAD_CYC - 1);
  localparam logic [PW-1:0] P_GUARD = PW'(GUARD_CYC - 1);
  state_t s, nxt;
  logic [WORD_W-1:0] sh;
  logic [BW-1:0] bc;
  logic [PW-1:0] pc;
  logic [7:0] cnt, cnt_d;
  logic par, pend, wr_ok, start, nb, level, bit_done, oe_q, oe_d, done_q, done_d;
  assign wr_ok = bus.cfg_wr && !pend;
  assign start = (s == LEAD && pc == P_LEAD) || (bit_done && bc != B_TOT);
  assign nb = bc < B_PRE ? 1'b1 : bc < B_DAT ? sh[WORD_W-1] : par;
  naneye_cfg_tx_enc #(.HALF_CYC(HALF_CYC)) enc (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bit_value(nb),
    .level(level),
    .bit_done(bit_done)
  );
  // state register with the registered outputs that track it
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= IDLE;
      oe_q <= 1'b0;
      done_q <= 1'b0;
      cnt <= '0;
    end else begin
      s <= nxt;
      oe_q <= oe_d;
      done_q <= done_d;
      cnt <= cnt_d;
    end
  end
  // next state from slot request, phase counter and position in the frame (bc = bits started)
  always_comb begin
    nxt = s;
    case (s)
      IDLE: nxt = bus.config_en ? ((pend || bus.cfg_wr) ? LEAD : DONE) : IDLE;
      LEAD: nxt = pc == P_LEAD ? PRE : LEAD;
      PRE, DATA, PARITY: nxt = !bit_done ? s : bc < B_PRE ? PRE : bc < B_DAT ? DATA : bc < B_TOT ? PARITY : GUARD;
      GUARD: nxt = pc == P_GUARD ? DONE : GUARD;
      default: nxt = IDLE;
    endcase
  end
  // outputs are decoded from the state being entered so the registers line up with it
  always_comb begin
    oe_d = nxt inside {LEAD, PRE, DATA, PARITY, GUARD};
    done_d = nxt == DONE;
    cnt_d = cnt + 8'(s == GUARD && nxt == DONE);
  end
  // shadow word: load on accepted write, shift MSB first as data bits start, release after the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      sh <= '0;
      par <= 1'b0;
      bc <= '0;
      pc <= '0;
    end else begin
      if (wr_ok) begin
        pend <= 1'b1;
        sh <= bus.cfg_data;
        par <= ^bus.cfg_data;
      end else if (s == DONE) pend <= 1'b0;
      else if (start && bc >= B_PRE && bc < B_DAT) sh <= sh << 1;
      bc <= s == IDLE ? '0 : bc + BW'(start);
      pc <= nxt != s ? '0 : pc + 1'b1;
    end
  end
  assign bus.cfg_busy = pend;
  assign bus.config_done = done_q;
  assign bus.ser_out = level;
  assign bus.ser_oe = oe_q;
  assign bus.tx_count = cnt;
endmodule

// File: tb/tb_naneye_cfg_tx.sv
// tb_naneye_cfg_tx: scoreboard bench decoding Manchester frames off the line
module tb_naneye_cfg_tx;
  localparam int HALF = 2, LEAD = 4, GUARD = 4, NBITS = 19, FRAME = LEAD + 2 * HALF * NBITS + GUARD;
  localparam int LAT = FRAME + 1;
  logic clk = 0, rst = 1;
  int checks = 0, errors = 0, cyc = 0, en_cyc = 0, oe_rises = 0, flen = 0;
  logic prev_oe = 0, abort_ok = 0;
  logic samp [0:127];
  logic [15:0] sb [$];
  logic [7:0] cnt_exp = 0;

  naneye_cfg_tx_if #(.WORD_W(16)) bus ();
  naneye_cfg_tx #(.WORD_W(16), .PRE_BITS(2), .HALF_CYC(HALF), .LEAD_CYC(LEAD), .GUARD_CYC(GUARD)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic decode_frame();
    logic [15:0] w;
    logic [NBITS-1:0] eb;
    logic e;
    int p;
    if (abort_ok) begin
      abort_ok = 0;
      checks++;
      if (flen >= FRAME) begin errors++; $display("FAIL abort_len: oe high %0d cycles, required fewer than %0d", flen, FRAME); end
      return;
    end
    checks++;
    if (flen != FRAME) begin errors++; $display("FAIL frame_len: oe high %0d cycles, required %0d", flen, FRAME); end
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL frame_unexpected: frame on line, scoreboard empty"); return; end
    w = sb.pop_front();
    eb = {2'b11, w, ^w};
    for (int b = 0; b < NBITS; b++) begin
      e = eb[NBITS-1-b];
      p = LEAD + 2 * HALF * b;
      checks++;
      if (samp[p] !== e || samp[p+1] !== e || samp[p+2] !== !e || samp[p+3] !== !e) begin
        errors++;
        $display("FAIL frame_bit%0d word %h: halves %b%b|%b%b, required %b%b|%b%b", b, w, samp[p], samp[p+1], samp[p+2], samp[p+3], e, e, !e, !e);
      end
    end
    for (int k = 0; k < FRAME; k++)
      if (k < LEAD || k >= LEAD + 2 * HALF * NBITS) begin
        checks++;
        if (samp[k] !== 1'b0) begin errors++; $display("FAIL frame_turnaround cycle %0d: ser_out %b, required 0", k, samp[k]); end
      end
  endtask

  // line monitor: idle line must be low; capture each driven window and decode it when oe drops
  always @(negedge clk) begin
    if (bus.ser_oe !== 1'b1) begin
      checks++;
      if (bus.ser_out !== 1'b0) begin errors++; $display("FAIL line_idle: ser_out %b with ser_oe %b, required 0", bus.ser_out, bus.ser_oe); end
      if (prev_oe) decode_frame();
    end else begin
      if (!prev_oe) begin flen = 0; oe_rises++; end
      if (flen < 128) samp[flen] = bus.ser_out;
      flen++;
    end
    prev_oe = bus.ser_oe === 1'b1;
  end

  task automatic do_write(input logic [15:0] d);
    @(negedge clk);
    bus.cfg_wr = 1;
    bus.cfg_data = d;
    @(negedge clk);
    bus.cfg_wr = 0;
  endtask

  task automatic pulse_en();
    @(negedge clk);
    bus.config_en = 1;
    en_cyc = cyc;
    @(negedge clk);
    bus.config_en = 0;
  endtask

  task automatic wait_done();
    while (bus.config_done !== 1'b1 && cyc - en_cyc < 300) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    bus.cfg_wr = 0;
    bus.cfg_data = 0;
    bus.config_en = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cfg_busy !== 0 || bus.config_done !== 0) begin errors++; $display("FAIL reset_ctrl: busy %b done %b, required 0 0", bus.cfg_busy, bus.config_done); end
    checks++;
    if (bus.ser_out !== 0 || bus.ser_oe !== 0 || bus.tx_count !== 0) begin errors++; $display("FAIL reset_line: out %b oe %b count %0d, required 0 0 0", bus.ser_out, bus.ser_oe, bus.tx_count); end
    rst = 0;
  endtask

  task automatic test_frame();
    do_write(16'hA5C3);
    sb.push_back(16'hA5C3);
    checks++;
    if (bus.cfg_busy !== 1) begin errors++; $display("FAIL frame_busy: busy %b after write, required 1", bus.cfg_busy); end
    pulse_en();
    wait_done();
    cnt_exp++;
    checks++;
    if (cyc - en_cyc != LAT) begin errors++; $display("FAIL frame_latency: %0d, required %0d", cyc - en_cyc, LAT); end
    checks++;
    if (bus.tx_count !== cnt_exp || bus.cfg_busy !== 1) begin errors++; $display("FAIL frame_done_cycle: count %0d busy %b, required %0d 1", bus.tx_count, bus.cfg_busy, cnt_exp); end
    @(negedge clk);
    checks++;
    if (bus.config_done !== 0 || bus.cfg_busy !== 0) begin errors++; $display("FAIL frame_after: done %b busy %b, required 0 0", bus.config_done, bus.cfg_busy); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL frame_decoded: %0d words left, required 0", sb.size()); end
  endtask

  task automatic test_empty();
    int r0;
    r0 = oe_rises;
    pulse_en();
    wait_done();
    checks++;
    if (cyc - en_cyc != 1) begin errors++; $display("FAIL empty_latency: %0d, required 1", cyc - en_cyc); end
    repeat (10) @(negedge clk);
    checks++;
    if (oe_rises != r0 || bus.tx_count !== cnt_exp || bus.cfg_busy !== 0) begin
      errors++; $display("FAIL empty_slot: oe rises %0d count %0d busy %b, required %0d %0d 0", oe_rises - r0, bus.tx_count, bus.cfg_busy, 0, cnt_exp);
    end
  endtask

  task automatic test_write_during_frame();
    do_write(16'h1234);
    sb.push_back(16'h1234);
    pulse_en();
    repeat (18) @(negedge clk);
    do_write(16'h0001);
    checks++;
    if (bus.cfg_busy !== 1) begin errors++; $display("FAIL midframe_busy: busy %b, required 1", bus.cfg_busy); end
    wait_done();
    cnt_exp++;
    checks++;
    if (cyc - en_cyc != LAT || bus.cfg_busy !== 1) begin errors++; $display("FAIL midframe_done: latency %0d busy %b, required %0d 1", cyc - en_cyc, bus.cfg_busy, LAT); end
    bus.cfg_wr = 1;
    bus.cfg_data = 16'hBEEF;
    @(negedge clk);
    bus.cfg_wr = 0;
    checks++;
    if (bus.cfg_busy !== 0 || bus.tx_count !== cnt_exp) begin errors++; $display("FAIL done_write_ignored: busy %b count %0d, required 0 %0d", bus.cfg_busy, bus.tx_count, cnt_exp); end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL midframe_decoded: %0d words left, required 0", sb.size()); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    bus.cfg_wr = 1;
    bus.cfg_data = 16'hFFFF;
    bus.config_en = 1;
    en_cyc = cyc;
    sb.push_back(16'hFFFF);
    @(negedge clk);
    bus.cfg_wr = 0;
    bus.config_en = 0;
    wait_done();
    cnt_exp++;
    checks++;
    if (cyc - en_cyc != LAT || bus.tx_count !== cnt_exp) begin errors++; $display("FAIL same_cycle: latency %0d count %0d, required %0d %0d", cyc - en_cyc, bus.tx_count, LAT, cnt_exp); end
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL same_cycle_decoded: %0d words left, required 0", sb.size()); end
  endtask

  task automatic test_reset_abort();
    int dones;
    do_write(16'h5A5A);
    abort_ok = 1;
    pulse_en();
    while (cyc - en_cyc < 40) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if (bus.ser_oe !== 0 || bus.cfg_busy !== 0 || bus.config_done !== 0 || bus.ser_out !== 0) begin
      errors++; $display("FAIL abort_state: oe %b busy %b done %b out %b, required 0 0 0 0", bus.ser_oe, bus.cfg_busy, bus.config_done, bus.ser_out);
    end
    rst = 0;
    cnt_exp = 0;
    checks++;
    if (bus.tx_count !== cnt_exp) begin errors++; $display("FAIL abort_count: %0d, required 0", bus.tx_count); end
    dones = 0;
    repeat (120) begin
      @(negedge clk);
      if (bus.config_done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || abort_ok !== 0) begin errors++; $display("FAIL abort_no_done: dones %0d abort pending %b, required 0 0", dones, abort_ok); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom_range(0, 65535));
      do_write(w);
      sb.push_back(w);
      pulse_en();
      wait_done();
      cnt_exp++;
      checks++;
      if (cyc - en_cyc != LAT || bus.tx_count !== cnt_exp) begin
        errors++; $display("FAIL b2b_frame%0d: latency %0d count %0d, required %0d %0d", i, cyc - en_cyc, bus.tx_count, LAT, cnt_exp);
      end
    end
    checks++;
    if (bus.tx_count !== 8'd0) begin errors++; $display("FAIL b2b_wrap: count %0d, required 0", bus.tx_count); end
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL b2b_decoded: %0d words left, required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_empty();
    test_write_during_frame();
    test_same_cycle();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
